vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

VGA timing generator and pixel output stage driving the board's VGA pins from the 50 MHz clock. It divides CLOCK_50 by two to form the 25 MHz pixel rate and produces the 640x480@60 raster coordinates and video_on consumed by the drawing logic. It registers the returned colour and the horizontal and vertical syncs so that VGA_R/G/B, VGA_HS and VGA_VS are pixel-aligned. It sits between the drawing logic (coordinate consumer, colour producer) and the top-level VGA pins, i.e. it is the transmitting end of the VGA capture path.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- Constraints: H_TOTAL = sum of the H_* parameters ≤ 1024; V_TOTAL = sum of the V_* parameters ≤ 1024.

Ports (one clock; reset is synchronous and active-high):
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- rgb_in  in  24  {R,G,B} colour for the current pixel_x/pixel_y, supplied by the drawing logic
- pixel_x  out  10  horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  vertical count, 0..V_TOTAL-1
- video_on  out  1  high when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
- pixel_tick  out  1  one-CLOCK_50 strobe marking the last clock of each pixel period
- frame_start  out  1  one-clock pulse at the pixel (0,0) tick
- VGA_HS  out  1  horizontal sync, active-low
- VGA_VS  out  1  vertical sync, active-low
- VGA_R, VGA_G, VGA_B  out  8 each  registered colour; 0 outside the active area

## Operation
- Internal registers:
  - tick flag: toggles every clock; pixel_tick is this flag, registered.
  - h_cnt and v_cnt: 10-bit each; pixel_x = h_cnt and pixel_y = v_cnt, taken directly from the registers.
- Counter advance (on a clock with pixel_tick=1):
  - h_cnt: H_TOTAL-1 wraps to 0, otherwise increments.
  - v_cnt: increments only when h_cnt wraps; V_TOTAL-1 wraps to 0.
  - Neither counter changes on clocks with pixel_tick=0.
- Sync windows, decoded from the current counters:
  - hsync_act = H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
  - vsync_act = V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491 by default).
- Output stage (loads on a clock with pixel_tick=1):
  - VGA_R/G/B ← video_on ? rgb_in : 0.
  - VGA_HS ← ~hsync_act; VGA_VS ← ~vsync_act.
  - The output stage holds its value on all other clocks.
- video_on and frame_start are combinational from the registers. frame_start = pixel_tick & (h_cnt==0) & (v_cnt==0).
- There is no state machine beyond the counters; the frame period is the fixed count 2·H_TOTAL·V_TOTAL clocks.

## Timing
- Reset values, on the clock after reset is sampled high:
  - tick=0, pixel_tick=0, h_cnt=0, v_cnt=0, frame_start=0.
  - VGA_HS=1, VGA_VS=1, VGA_R=VGA_G=VGA_B=0.
  - video_on=1, because (0,0) is active.
- Reset has priority over every other update. Asserting reset mid-frame returns all registers to their reset values on the next edge, with no partial-line completion.
- First clock after reset release: pixel_tick=0. Second clock: pixel_tick=1 and frame_start=1. Thereafter pixel_tick alternates 0,1.
- Each pixel lasts exactly 2 clocks. pixel_x/pixel_y change on the edge that ends a pixel_tick=1 clock.
- rgb_in is sampled on the pixel_tick=1 clock, so the drawing logic has 2 clocks after a coordinate change to settle the colour.
- Output latency: VGA_R/G/B, VGA_HS and VGA_VS for coordinate (x,y) appear one pixel period (2 clocks) after pixel_x/pixel_y first show (x,y). They hold for 2 clocks.
- Colour and syncs are produced by the same register stage, so they are always mutually aligned.
- Default line period: 1600 clocks. Default frame period: 840 000 clocks, giving 59.52 Hz.
- Simultaneous h wrap and v wrap (799,524 → 0,0): both counters reach 0 on the same edge. frame_start then fires on the next pixel_tick=1 clock.

## Test plan
- Reset and start-up:
  - Stimulus: hold reset 3 clocks, then release.
  - Required on release: all outputs at their reset values, pixel_tick = 0,1,0,1..., frame_start=1 only on the 2nd clock, and pixel_x=1 on the 3rd clock.
- Line wrap:
  - Run to pixel_x=799, pixel_y=0.
  - Required: the next pixel gives pixel_x=0, pixel_y=1. video_on falls at pixel_x=640 and rises at pixel_x=0 on line 1.
- Horizontal sync:
  - Required: VGA_HS is 0 for exactly 96 pixel periods (192 clocks) per line, first low 2 clocks after pixel_x becomes 656, and high again 2 clocks after pixel_x becomes 752.
- Vertical sync and frame:
  - Required: VGA_VS is low for exactly 2 lines (3200 clocks), starting 2 clocks after (0,490).
  - Required: consecutive frame_start pulses are 840 000 clocks apart, and pixel_y never exceeds 524.
- Colour blanking and latency:
  - Stimulus: drive rgb_in = {pixel_x[7:0], pixel_y[7:0], 8'hA5}.
  - Required: at x=5,y=3, VGA_R/G/B = 5/3/0xA5, two clocks after pixel_x=5.
  - Required: at x=700 (blanking), VGA_R/G/B = 0/0/0.
- Reset mid-frame:
  - Stimulus: assert reset for 1 clock at (321,200).
  - Required: the next clock shows pixel_x=0, pixel_y=0, VGA_HS=VGA_VS=1, and colour 0. The frame restarts with the same start-up sequence as the reset scenario.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: divides CLOCK_50 by two into a pixel strobe, runs the
// h/v raster counters and registers colour and syncs so they leave aligned to the pixel grid.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [23:0] rgb_in,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        video_on,
  output logic        pixel_tick,
  output logic        frame_start,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Window bounds are 11 bits so a sync ending exactly at 1024 still compares correctly.
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEGIN  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEGIN  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic        tick_q, tick_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;

  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic        hsync_act;
  logic        vsync_act;
  logic        active;

  assign h_ext     = {1'b0, h_cnt_q};
  assign v_ext     = {1'b0, v_cnt_q};
  assign active    = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
  assign hsync_act = (h_ext >= HS_BEGIN) && (h_ext < HS_END);
  assign vsync_act = (v_ext >= VS_BEGIN) && (v_ext < VS_END);

  always_comb begin
    tick_d  = ~tick_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    rgb_d   = rgb_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    if (tick_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
      // Output stage samples the pixel that is just ending, hence the one-pixel latency.
      rgb_d = active ? rgb_in : 24'h0;
      hs_d  = ~hsync_act;
      vs_d  = ~vsync_act;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tick_q  <= 1'b0;
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
      rgb_q   <= 24'h0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else begin
      tick_q  <= tick_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  assign pixel_x     = h_cnt_q;
  assign pixel_y     = v_cnt_q;
  assign video_on    = active;
  assign pixel_tick  = tick_q;
  assign frame_start = tick_q && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a clock-count raster model predicts every output each
// cycle; a short vertical frame keeps whole frames, vsync and frame wrap within the run.
module tb_vga_sync_gen;

  localparam int HA  = 640;
  localparam int HF  = 16;
  localparam int HSW = 96;
  localparam int HB  = 48;
  localparam int VA  = 8;
  localparam int VF  = 2;
  localparam int VSW = 2;
  localparam int VB  = 3;
  localparam int HT  = HA + HF + HSW + HB;
  localparam int VT  = VA + VF + VSW + VB;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        von;
    logic        tick;
    logic        fs;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] rgb_in = '0;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, pixel_tick, frame_start, VGA_HS, VGA_VS;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .rgb_in(rgb_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .pixel_tick(pixel_tick), .frame_start(frame_start),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #10 clk = ~clk;

  // Model: the whole raster is a function of clocks elapsed since the last reset edge.
  function automatic logic [9:0] fx(input int kk);
    return 10'((kk / 2) % HT);
  endfunction

  function automatic logic [9:0] fy(input int kk);
    return 10'(((kk / 2) / HT) % VT);
  endfunction

  function automatic logic in_act(input int kk);
    return (int'(fx(kk)) < HA) && (int'(fy(kk)) < VA);
  endfunction

  function automatic exp_t make_exp(input int kk, input logic [23:0] rgb);
    exp_t e;
    int   px, py;
    e.x    = fx(kk);
    e.y    = fy(kk);
    e.von  = in_act(kk);
    e.tick = logic'(kk % 2);
    e.fs   = e.tick && (e.x == 10'd0) && (e.y == 10'd0);
    e.rgb  = rgb;
    if (kk < 2) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
    end else begin
      px   = int'(fx(kk - 2));
      py   = int'(fy(kk - 2));
      e.hs = !((px >= HA + HF) && (px < HA + HF + HSW));
      e.vs = !((py >= VA + VF) && (py < VA + VF + VSW));
    end
    return e;
  endfunction

  exp_t        exp_q[$];
  int          k = 0;
  bit          started = 1'b0;
  logic [23:0] m_rgb = '0;
  int          rst_cnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      started = 1'b1;
      k       = 0;
      m_rgb   = '0;
      rst_cnt = rst_cnt + 1;
    end else if (started) begin
      if (k % 2 == 1) m_rgb = in_act(k) ? rgb_in : 24'h0;
      k = k + 1;
    end
    if (started) exp_q.push_back(make_exp(k, m_rgb));
  end

  // Drawing logic stand-in: colour carries the coordinate plus a per-clock random byte.
  always @(negedge clk) begin
    logic [9:0] dx, dy;
    dx     = fx(k);
    dy     = fy(k);
    rgb_in = {dx[7:0], dy[7:0], 8'($urandom)};
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rst_seen = 0;
  int hs_run = 0, vs_run = 0;
  int fs_last = 0;
  bit fs_have = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      vectors++;
      if (pixel_x !== e.x || pixel_y !== e.y || video_on !== e.von || pixel_tick !== e.tick ||
          frame_start !== e.fs || VGA_HS !== e.hs || VGA_VS !== e.vs ||
          {VGA_R, VGA_G, VGA_B} !== e.rgb) begin
        miscompares++;
        $display("FAIL raster cyc=%0d got x=%0d y=%0d von=%b tick=%b fs=%b hs=%b vs=%b rgb=%h exp x=%0d y=%0d von=%b tick=%b fs=%b hs=%b vs=%b rgb=%h",
                 cyc, pixel_x, pixel_y, video_on, pixel_tick, frame_start, VGA_HS, VGA_VS,
                 {VGA_R, VGA_G, VGA_B}, e.x, e.y, e.von, e.tick, e.fs, e.hs, e.vs, e.rgb);
      end
      if (rst_cnt != rst_seen) begin
        rst_seen = rst_cnt;
        hs_run   = 0;
        vs_run   = 0;
        fs_have  = 1'b0;
      end else begin
        if (VGA_HS === 1'b0) hs_run++;
        else if (hs_run != 0) begin
          vectors++;
          if (hs_run != 2 * HSW) begin
            miscompares++;
            $display("FAIL hs_low_width got %0d clocks exp %0d", hs_run, 2 * HSW);
          end
          hs_run = 0;
        end
        if (VGA_VS === 1'b0) vs_run++;
        else if (vs_run != 0) begin
          vectors++;
          if (vs_run != 2 * HT * VSW) begin
            miscompares++;
            $display("FAIL vs_low_width got %0d clocks exp %0d", vs_run, 2 * HT * VSW);
          end
          vs_run = 0;
        end
        if (frame_start === 1'b1) begin
          if (fs_have) begin
            vectors++;
            if (cyc - fs_last != 2 * HT * VT) begin
              miscompares++;
              $display("FAIL frame_period got %0d clocks exp %0d", cyc - fs_last, 2 * HT * VT);
            end
          end
          fs_have = 1'b1;
          fs_last = cyc;
        end
      end
    end
  end

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (k < target && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // Through a full frame into the next, then a one-clock reset while at (321,5).
    run_to(2 * (HT * VT + 5 * HT + 321));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat ($urandom_range(3000, 100)) @(negedge clk);
    reset = 1'b1;
    repeat ($urandom_range(4, 1)) @(negedge clk);
    reset = 1'b0;
    repeat (2 * HT * VT + 200) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
